// File: rtl/login_pkg.sv
// Shared definitions for the login datapath: scan FSM states, default sizing,
// and the pass/fail display codes shared with the login checker.
package login_pkg;

  localparam int          DEF_DATA_W       = 32;
  localparam int          DEF_NUM_ENTRIES  = 8;
  localparam int          DEF_ADDR_W       = 3;
  localparam logic [31:0] DEF_SCRAMBLE_KEY = 32'hA5A5_5A5A;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    EMIT   = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } scanState_t;

  typedef enum logic [1:0] {
    PF_BLANK  = 2'd0,
    PF_PASS   = 2'd1,
    PF_DENIED = 2'd2
  } passFail_t;

endpackage

// File: rtl/rom_credential_reader.sv
// Walks the credential ROM on each login request and streams every word to the
// checker as a spaced one-cycle pulse. Build option CRED_SCRAMBLE_EN de-obfuscates words.
module rom_credential_reader
  import login_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ROM_LATENCY = 2
`ifdef CRED_SCRAMBLE_EN
  ,
  parameter logic [DATA_W-1:0] SCRAMBLE_KEY = DATA_W'(DEF_SCRAMBLE_KEY)
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoginReq,
  input  logic              MatchIn,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomData,
  output logic [DATA_W-1:0] ROMMemoryOut,
  output logic              ROMMemoryValid,
  output logic              Busy,
  output logic              Done,
  output logic              Hit
);

  localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'(ROM_LATENCY - 1);

  scanState_t        state, nextState;
  logic [ADDR_W-1:0] index;
  logic [CNT_W-1:0]  waitCnt;
  logic [DATA_W-1:0] captureWord;
  logic              matchStop;

`ifdef CRED_SCRAMBLE_EN
  assign captureWord = RomData ^ SCRAMBLE_KEY;
`else
  assign captureWord = RomData;
`endif

  assign RomAddr = index;

  // A restart request always beats a match; FINISH already ends the scan.
  always_comb begin
    nextState = state;
    matchStop = 1'b0;
    case (state)
      IDLE:    if (LoginReq) nextState = ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (waitCnt == '0) nextState = EMIT;
      EMIT:    nextState = GAP;
      GAP:     nextState = (index == LAST_IDX) ? FINISH : ISSUE;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (LoginReq) begin
      nextState = ISSUE;
    end else if (MatchIn && state != IDLE && state != FINISH) begin
      nextState = FINISH;
      matchStop = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state          <= IDLE;
      index          <= '0;
      waitCnt        <= '0;
      ROMMemoryOut   <= '0;
      ROMMemoryValid <= 1'b0;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Hit            <= 1'b0;
    end else begin
      state          <= nextState;
      ROMMemoryValid <= (nextState == EMIT);
      Done           <= (nextState == FINISH);
      Busy           <= (nextState != IDLE) && (nextState != FINISH);
      if (nextState == FINISH) Hit <= matchStop;

      if (LoginReq)
        index <= '0;
      else if (state == GAP && nextState == ISSUE)
        index <= index + ADDR_W'(1);

      if (state == ISSUE)
        waitCnt <= WAIT_LOAD;
      else if (state == WAIT && waitCnt != '0)
        waitCnt <= waitCnt - CNT_W'(1);

      // RomData is only trusted on the final WAIT cycle.
      if (state == WAIT && waitCnt == '0 && nextState == EMIT)
        ROMMemoryOut <= captureWord;
    end
  end

endmodule

// File: tb/tb_rom_credential_reader.sv
// Directed bench for rom_credential_reader: two instances (ROM latency 2 and 1),
// each fed by a cycle-accurate synchronous ROM model.
module tb_rom_credential_reader;
  import login_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        loginReqA, loginReqB, matchIn;
  logic [2:0]  romAddrA, romAddrB;
  logic [31:0] romDataA, romDataB, romPipeA;
  logic [31:0] outA, outB;
  logic        validA, validB, busyA, busyB, doneA, doneB, hitA, hitB;
  int          checkCount = 0;
  int          errorCount = 0;
  int          pulsesB;

  always #5 Clk = ~Clk;

  rom_credential_reader dutA (
    .Clk(Clk), .Reset(Reset), .LoginReq(loginReqA), .MatchIn(matchIn),
    .RomAddr(romAddrA), .RomData(romDataA), .ROMMemoryOut(outA),
    .ROMMemoryValid(validA), .Busy(busyA), .Done(doneA), .Hit(hitA)
  );

  rom_credential_reader #(.ROM_LATENCY(1)) dutB (
    .Clk(Clk), .Reset(Reset), .LoginReq(loginReqB), .MatchIn(1'b0),
    .RomAddr(romAddrB), .RomData(romDataB), .ROMMemoryOut(outB),
    .ROMMemoryValid(validB), .Busy(busyB), .Done(doneB), .Hit(hitB)
  );

  function automatic logic [31:0] romWord(input int i);
`ifdef CRED_SCRAMBLE_EN
    return 32'hA5A5_5A5A + 32'(i);
`else
    return 32'h1000_0000 + 32'(i);
`endif
  endfunction

  function automatic logic [31:0] expData(input int i);
`ifdef CRED_SCRAMBLE_EN
    return romWord(i) ^ 32'hA5A5_5A5A;
`else
    return romWord(i);
`endif
  endfunction

  // Synchronous ROMs: two register stages for dutA, one for dutB.
  always @(posedge Clk) begin
    romPipeA <= romWord(int'(romAddrA));
    romDataA <= romPipeA;
    romDataB <= romWord(int'(romAddrB));
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs are sampled at the next rising edge; outputs are read 1ns later.
  task automatic applyStimulus(input logic lrA, input logic mi, input logic rst, input logic lrB);
    loginReqA = lrA;
    matchIn   = mi;
    Reset     = rst;
    loginReqB = lrB;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"},  32'(romAddrA), 32'd0);
    checkOutput({tag, "_out"},   outA,          32'd0);
    checkOutput({tag, "_valid"}, 32'(validA),   32'd0);
    checkOutput({tag, "_busy"},  32'(busyA),    32'd0);
    checkOutput({tag, "_done"},  32'(doneA),    32'd0);
    checkOutput({tag, "_hit"},   32'(hitA),     32'd0);
  endtask

  initial begin
    bit expV;
    int j;

    loginReqA = 1'b0; loginReqB = 1'b0; matchIn = 1'b0; Reset = 1'b0;
    #2;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkAllZero("reset");
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("idle_match_busy", 32'(busyA), 32'd0);
    checkOutput("idle_match_done", 32'(doneA), 32'd0);

    // Full unmatched scan: pulses at edges 3,8,...,38, Done at 40.
    for (int k = 0; k <= 43; k++) begin
      applyStimulus(k == 0, 0, 1, 0);
      expV = (k >= 3) && (k <= 38) && ((k - 3) % 5 == 0);
      checkOutput($sformatf("full_valid_e%0d", k), 32'(validA), 32'(expV));
      if (expV) begin
        j = (k - 3) / 5;
        checkOutput($sformatf("full_data_e%0d", k), outA, expData(j));
        checkOutput($sformatf("full_addr_e%0d", k), 32'(romAddrA), 32'(j));
      end
      checkOutput($sformatf("full_done_e%0d", k), 32'(doneA), 32'(k == 40));
      checkOutput($sformatf("full_busy_e%0d", k), 32'(busyA), 32'(k < 40));
      if (k == 40) checkOutput("full_hit", 32'(hitA), 32'd0);
    end
    checkOutput("full_hold_out", outA, expData(7));

    // Match sampled at edge 14 ends the scan after the third pulse.
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(k == 0, k == 14, 1, 0);
      expV = (k == 3) || (k == 8) || (k == 13);
      checkOutput($sformatf("match_valid_e%0d", k), 32'(validA), 32'(expV));
      if (k == 13) checkOutput("match_data3", outA, expData(2));
      checkOutput($sformatf("match_done_e%0d", k), 32'(doneA), 32'(k == 14));
      checkOutput($sformatf("match_busy_e%0d", k), 32'(busyA), 32'(k < 14));
      if (k == 14) checkOutput("match_hit", 32'(hitA), 32'd1);
    end

    // Restart at edge 10, with a simultaneous match that must lose.
    for (int k = 0; k <= 20; k++) begin
      applyStimulus(k == 0 || k == 10, k == 10, 1, 0);
      expV = (k == 3) || (k == 8) || (k == 13) || (k == 18);
      checkOutput($sformatf("restart_valid_e%0d", k), 32'(validA), 32'(expV));
      if (k == 10) checkOutput("restart_addr", 32'(romAddrA), 32'd0);
      if (k == 13) checkOutput("restart_data0", outA, expData(0));
      if (k == 18) checkOutput("restart_data1", outA, expData(1));
      checkOutput($sformatf("restart_done_e%0d", k), 32'(doneA), 32'd0);
      checkOutput($sformatf("restart_busy_e%0d", k), 32'(busyA), 32'd1);
    end

    // Reset during WAIT at edge 12: immediate abort, no Done afterwards.
    for (int k = 0; k <= 16; k++) begin
      applyStimulus(k == 0, 0, k != 12, 0);
      if (k == 12) checkAllZero("midreset");
      if (k > 12) begin
        checkOutput($sformatf("midreset_done_e%0d", k), 32'(doneA), 32'd0);
        checkOutput($sformatf("midreset_busy_e%0d", k), 32'(busyA), 32'd0);
        checkOutput($sformatf("midreset_valid_e%0d", k), 32'(validA), 32'd0);
      end
    end
    for (int k = 0; k <= 4; k++) begin
      applyStimulus(k == 0, 0, 1, 0);
      if (k == 0) checkOutput("postreset_addr", 32'(romAddrA), 32'd0);
      checkOutput($sformatf("postreset_valid_e%0d", k), 32'(validA), 32'(k == 3));
      if (k == 3) checkOutput("postreset_data", outA, expData(0));
    end

    // Latency-1 instance: 4-cycle period, first pulse at edge 2, Done at 32.
    pulsesB = 0;
    for (int k = 0; k <= 34; k++) begin
      applyStimulus(0, 0, 1, k == 0);
      expV = (k >= 2) && (k <= 30) && ((k - 2) % 4 == 0);
      if (validB) pulsesB++;
      checkOutput($sformatf("lat1_valid_e%0d", k), 32'(validB), 32'(expV));
      if (expV) checkOutput($sformatf("lat1_data_e%0d", k), outB, expData((k - 2) / 4));
      checkOutput($sformatf("lat1_done_e%0d", k), 32'(doneB), 32'(k == 32));
      if (k == 32) checkOutput("lat1_hit", 32'(hitB), 32'd0);
    end
    checkOutput("lat1_pulse_count", 32'(pulsesB), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rom_credential_reader.md
Name: rom_credential_reader

Overview:
- Producer side of the credential-check stream.
- On a login request, the block walks the credential ROM from entry 0 to NUM_ENTRIES-1.
- Each 32-bit word is presented to the login checker as a one-cycle ROMMemoryValid pulse, with at least one idle cycle between pulses.
- It sits between the synchronous credential ROM and the login checker. It stops early when the checker reports a match.

Parameters:
- DATA_W, 32, credential word width (ID+password).
- NUM_ENTRIES, 8, number of ROM entries scanned per request.
- ADDR_W, 3, ROM address width; 2**ADDR_W >= NUM_ENTRIES.
- ROM_LATENCY, 2, cycles from RomAddr registered to RomData valid; legal range >= 1.
- SCRAMBLE_KEY, 32'hA5A5_5A5A, XOR key used only when the optional feature is compiled in.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-low reset.
- LoginReq  in  1  one-cycle pulse: credentials are fully entered; start or restart the scan.
- MatchIn  in  1  checker's start/match indication; high means stop scanning.
- RomAddr  out  ADDR_W  registered ROM address.
- RomData  in  DATA_W  ROM read data, valid ROM_LATENCY cycles after RomAddr.
- ROMMemoryOut  out  DATA_W  registered word presented to the checker.
- ROMMemoryValid  out  1  one-cycle qualifier for ROMMemoryOut.
- Busy  out  1  high while a scan is in progress.
- Done  out  1  one-cycle pulse when a scan ends.
- Hit  out  1  sampled with Done: 1 = ended by match, 0 = ROM exhausted.

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - state=IDLE.
  - RomAddr=0, ROMMemoryOut=0, ROMMemoryValid=0, Busy=0, Done=0, Hit=0.
  - Entry index=0, wait counter=0.
  - Reset mid-scan aborts immediately; no Done pulse is produced.
- States: IDLE, ISSUE, WAIT, EMIT, GAP, FINISH.
- IDLE:
  - LoginReq=1 -> ISSUE, index=0, RomAddr=0, Busy=1.
  - MatchIn is ignored in IDLE.
- ISSUE (1 cycle): RomAddr holds the index; load wait counter=ROM_LATENCY-1; -> WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture RomData into ROMMemoryOut and -> EMIT. WAIT lasts ROM_LATENCY cycles in total.
- EMIT (1 cycle): ROMMemoryValid=1; -> GAP.
- GAP (1 cycle): ROMMemoryValid=0.
  - If index==NUM_ENTRIES-1 -> FINISH with Hit=0.
  - Otherwise index+1, RomAddr=index+1, -> ISSUE.
- FINISH (1 cycle): Done=1, Busy=0; -> IDLE. ROMMemoryOut holds its last value.
- Timing:
  - Per-entry period is ROM_LATENCY+3 cycles.
  - With defaults, LoginReq sampled at edge 0 gives ROMMemoryValid high between edges 3 and 4.
  - Subsequent pulses occur every 5 cycles.
  - Exactly NUM_ENTRIES pulses are produced per unmatched scan.
- MatchIn=1 in any non-IDLE state:
  - Next state is FINISH with Hit=1.
  - ROMMemoryValid is forced to 0 that cycle, and no further pulses are emitted.
- LoginReq=1 while Busy: the scan restarts (index=0, -> ISSUE), with no Done for the abandoned scan.
- LoginReq and MatchIn high in the same cycle: LoginReq wins.
- Index arithmetic is ADDR_W bits and never wraps: the terminal check happens at NUM_ENTRIES-1.
- RomData is not sampled outside WAIT.

Optional Feature:
- Macro: CRED_SCRAMBLE_EN.
- Defined: ROMMemoryOut captures RomData XOR SCRAMBLE_KEY, so the ROM stores obfuscated credentials. Timing is unchanged.
- Undefined: ROMMemoryOut captures RomData unmodified, and SCRAMBLE_KEY is unused.

Decomposition:
- Shared package login_pkg holds:
  - state enumeration (IDLE..FINISH, 3-bit encoding).
  - default DATA_W, NUM_ENTRIES, ADDR_W, SCRAMBLE_KEY.
  - PassFail display codes shared with the checker.
- No sub-module: a single FSM plus index and wait counters; expected size is about 150-200 lines.

Test Plan:
- ROM word i = 32'h1000_0000+i, LoginReq at edge 0, MatchIn=0 -> 8 valid pulses at edges 3,8,...,38 with RomAddr 0..7 and data 1000_0000..1000_0007, then Done=1 with Hit=0 at edge 40, Busy low after.
- Same stimulus with MatchIn pulsed the cycle after the 3rd pulse (edge 14) -> no 4th pulse, Done=1 with Hit=1 next cycle, state IDLE.
- LoginReq re-asserted at edge 10 mid-scan -> no Done, RomAddr returns to 0, next valid at edge 13 carrying 1000_0000.
- Reset low at edge 12 mid-WAIT -> all outputs 0 at the next cycle, no Done; a later LoginReq starts cleanly from address 0.
- ROM_LATENCY=1 -> pulse period 4 cycles, first valid at edge 2, 8 pulses total.
- With CRED_SCRAMBLE_EN, ROM word 0 = 32'hA5A5_5A5A -> ROMMemoryOut=32'h0000_0000 on the first pulse.
